dense_fc_ram_sched: RTL
=======================

# dense_fc_ram_sched

Scheduler that shares the single-address dense FC RAM between a write requester (activation producer) and a burst-read requester (dense layer feeding the MAC array). Grants one RAM access per cycle, round-robin on conflict, sequences read bursts with address wrap. Returns read data through a 2-entry output buffer with valid/ready backpressure. Sits directly in front of the dense FC RAM; no other block drives that RAM's address.

## Interface
- DEPTH, 256: RAM depth in words; ADDR_W = $clog2(DEPTH).
- WIDTH, 8: data word width.
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- wr_valid / wr_ready  in / out  1  write request handshake; transfer when both high.
- wr_addr / wr_data  in  ADDR_W / WIDTH  write address and data.
- rd_start  in  1  one-cycle burst request; ignored unless rd_busy=0.
- rd_base / rd_len  in  ADDR_W / ADDR_W+1  burst start address, word count (0..DEPTH).
- rd_busy  out  1  burst accepted, not yet fully delivered.
- rd_done  out  1  one-cycle pulse after last word handed off.
- out_valid / out_ready  out / in  1  read data stream handshake.
- out_data  out  WIDTH  read word; out_last  out  1  marks final word of burst.
- ram_write_enable / ram_read_enable  out  1  RAM strobes; never both high.
- ram_addr  out  ADDR_W  shared RAM address; ram_data_in  out  WIDTH.
- ram_data_out  in  WIDTH  RAM registered read data, valid 1 cycle after ram_read_enable.

## Operation
- States: IDLE, BURST, DRAIN. IDLE -> BURST on rd_start with rd_len>0 (latch base, len). BURST -> DRAIN when all reads issued. DRAIN -> IDLE when last word accepted at output (rd_done pulses). rd_start with rd_len=0: stay IDLE, rd_done pulses next cycle, no reads.
- Read eligible in BURST only when issued_remaining>0 and buffer_count + inflight < 2 (credit rule; buffer never overflows).
- Write eligible whenever wr_valid=1. wr_ready = grant to write this cycle (combinational from arbiter).
- Conflict (write and read both eligible): round-robin; last_grant register flips to the winner; reset value = READ so first conflict goes to write.
- Read address = (rd_base + issued) mod DEPTH; natural ADDR_W wrap for power-of-two DEPTH, explicit compare-and-wrap otherwise.
- out_last set on word whose index = len-1. Write to an address inside an active burst is allowed; ordering is grant order (no hazard protection).
- rd_start while rd_busy=1: ignored, no effect on current burst.

## Timing
- Reset: state=IDLE, rd_busy=0, rd_done=0, out_valid=0, out_last=0, out_data=0, wr_ready=0, ram_* strobes=0, ram_addr=0, counters=0, buffer empty.
- rd_start at cycle T -> rd_busy=1 and first ram_read_enable at T+1 (if no write wins); ram_data_out at T+2; out_valid earliest T+2 (buffer write-through when empty and out_ready).
- Sustained throughput 1 word/cycle with out_ready=1 and no writes; with continuous wr_valid, reads get every other cycle.
- Write: RAM write occurs in the wr_valid&wr_ready cycle; no added latency.
- rd_done asserts the cycle after the out_last transfer; rd_busy falls same cycle.
- out_ready low: issue stalls once credits exhausted; data held stable, out_valid stays high.
- Reset mid-burst: all state cleared immediately; in-flight RAM read data discarded.

## Structure
- Package dense_fc_pkg: sched_state_e (IDLE, BURST, DRAIN), grant_e (GRANT_READ, GRANT_WRITE).
- Sub-module fc_out_skid: 2-entry valid/ready buffer, WIDTH+1 bits (data+last), count output for credit logic.
- Arbiter, counters and FSM in the top module.

## Test plan
- Reset then idle: all outputs 0, no RAM strobes for 10 cycles.
- Burst rd_base=4, rd_len=8, out_ready=1, no writes: reads addr 4..11 on consecutive cycles, 8 words out, out_last on 8th, rd_done 1 cycle later.
- Wrap: DEPTH=256, rd_base=254, rd_len=4 -> addresses 254,255,0,1 in order.
- Contention: wr_valid held high during 6-word burst -> grants alternate W/R starting with write; never both RAM strobes high; all 6 words delivered.
- Backpressure: out_ready low for 5 cycles mid-burst -> at most 2 words buffered, no loss or duplication, order preserved.
- rd_len=0 -> rd_done pulse next cycle, no ram_read_enable; rd_start during busy ignored; reset asserted mid-burst -> IDLE, out_valid=0 immediately.

Source files
------------

// File: rtl/dense_fc_pkg.sv
// Shared types for the dense FC RAM scheduler.
package dense_fc_pkg;

   typedef enum logic [1:0] {IDLE, BURST, DRAIN} sched_state_e;
   typedef enum logic {GRANT_READ, GRANT_WRITE} grant_e;

endpackage

// File: rtl/fc_out_skid.sv
// Two-entry valid/ready buffer for read data plus last flag; passes through when empty.
module fc_out_skid
   import dense_fc_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_last,
   output logic [1:0]       count
);

   logic [WIDTH:0] mem_q [2];
   logic           rd_ptr_q, wr_ptr_q;
   logic [1:0]     count_q;
   logic           bypass, store, pop;

   always_comb begin
      bypass    = in_valid && (count_q == 2'd0) && out_ready;
      store     = in_valid && !bypass;
      pop       = (count_q != 2'd0) && out_ready;
      out_valid = (count_q != 2'd0) || in_valid;
      if (count_q != 2'd0) begin
         {out_last, out_data} = mem_q[rd_ptr_q];
      end else if (in_valid) begin
         {out_last, out_data} = {in_last, in_data};
      end else begin
         {out_last, out_data} = '0;
      end
   end

   assign count = count_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (store) begin
            mem_q[wr_ptr_q] <= {in_last, in_data};
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         case ({store, pop})
            2'b10:   count_q <= count_q + 2'd1;
            2'b01:   count_q <= count_q - 2'd1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/dense_fc_ram_sched.sv
// Shares the single-port dense FC RAM between a write requester and a burst reader,
// one access per cycle, round-robin on conflict, read data returned through a 2-entry buffer.
module dense_fc_ram_sched
   import dense_fc_pkg::*;
#(
   parameter int unsigned DEPTH = 256,
   parameter int unsigned WIDTH = 8,
   localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WIDTH-1:0]  wr_data,
   input  logic              rd_start,
   input  logic [ADDR_W-1:0] rd_base,
   input  logic [ADDR_W:0]   rd_len,
   output logic              rd_busy,
   output logic              rd_done,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  out_data,
   output logic              out_last,
   output logic              ram_write_enable,
   output logic              ram_read_enable,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [WIDTH-1:0]  ram_data_in,
   input  logic [WIDTH-1:0]  ram_data_out
);

   sched_state_e      state_q;
   grant_e            last_grant_q;
   logic [ADDR_W:0]   len_q, issued_q;
   logic [ADDR_W-1:0] addr_q;
   logic              inflight_q, inflight_last_q, rd_done_q;
   logic [1:0]        skid_count;
   logic              credit_ok, rd_elig, grant_w, grant_r, last_issue, out_xfer;

   // Credit: words buffered plus the read in flight may never exceed the buffer depth.
   always_comb begin
      last_issue = (issued_q + (ADDR_W+1)'(1)) == len_q;
      credit_ok  = ({1'b0, skid_count} + {2'b0, inflight_q}) < 3'd2;
      rd_elig    = (state_q == BURST) && (issued_q != len_q) && credit_ok;
      grant_w    = wr_valid && !reset && (!rd_elig || (last_grant_q == GRANT_READ));
      grant_r    = rd_elig && !grant_w;
      out_xfer   = out_valid && out_ready;
   end

   assign wr_ready         = grant_w;
   assign ram_write_enable = grant_w;
   assign ram_read_enable  = grant_r;
   assign ram_addr         = grant_w ? wr_addr : (grant_r ? addr_q : '0);
   assign ram_data_in      = grant_w ? wr_data : '0;
   assign rd_busy          = (state_q != IDLE);
   assign rd_done          = rd_done_q;

   fc_out_skid #(
      .WIDTH(WIDTH)
   ) u_skid (
      .clk      (clk),
      .reset    (reset),
      .in_valid (inflight_q),
      .in_data  (ram_data_out),
      .in_last  (inflight_last_q),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .out_last (out_last),
      .count    (skid_count)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q         <= IDLE;
         last_grant_q    <= GRANT_READ;
         len_q           <= '0;
         issued_q        <= '0;
         addr_q          <= '0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
         rd_done_q       <= 1'b0;
      end else begin
         rd_done_q       <= 1'b0;
         inflight_q      <= grant_r;
         inflight_last_q <= grant_r && last_issue;
         if (rd_elig && wr_valid) begin
            last_grant_q <= grant_w ? GRANT_WRITE : GRANT_READ;
         end
         if (grant_r) begin
            issued_q <= issued_q + (ADDR_W+1)'(1);
            // Explicit wrap keeps non-power-of-two depths correct.
            addr_q   <= (addr_q == ADDR_W'(DEPTH - 1)) ? '0 : addr_q + ADDR_W'(1);
         end
         case (state_q)
            IDLE: begin
               if (rd_start) begin
                  if (rd_len == '0) begin
                     rd_done_q <= 1'b1;
                  end else begin
                     state_q  <= BURST;
                     len_q    <= rd_len;
                     issued_q <= '0;
                     addr_q   <= rd_base;
                  end
               end
            end
            BURST: begin
               if (grant_r && last_issue) begin
                  state_q <= DRAIN;
               end
            end
            DRAIN: begin
               if (out_xfer && out_last) begin
                  state_q   <= IDLE;
                  rd_done_q <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule
